m_ucode_seq: RTL and testbench

- Microcode sequencer for the 48-bit control-word ROM built from three EBRs.
- Each cycle it generates the 8-bit ROM read address `minx` and the ROM read enable `progress_ucode`.
- The next address comes from the sequencing fields of the word currently on the ROM output, the instruction opcode, a branch condition, interrupt requests and a memory-stall input.
- A stall watchdog forces a trap entry when a memory stall lasts too long.

---
 rtl/m_ucode_seq.sv | 116 +++++++++++
 tb/tb_m_ucode_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/m_ucode_seq.sv
`timescale 1ns/1ps
// m_ucode_seq: next-address generator for the 48-bit microcode ROM.
// Picks the ROM read address each cycle from the sequencing field of the word
// on the ROM output, the opcode dispatch table, interrupts and memory stalls.
// A stall watchdog diverts to TRAP_VEC when a stall runs too long.
module m_ucode_seq #(
    parameter logic [7:0] RESET_VEC = 8'h00,
    parameter logic [7:0] DISP_BASE = 8'h20,
    parameter logic [7:0] IRQ_VEC   = 8'h08,
    parameter logic [7:0] TRAP_VEC  = 8'h04,
    parameter int         TIMEOUT   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ucode_naddr,
    input  logic [1:0] ucode_seq,
    input  logic       cond,
    input  logic [4:0] opcode,
    input  logic       irq,
    input  logic       mem_busy,
    output logic [7:0] minx,
    output logic       progress_ucode,
    output logic       irq_ack,
    output logic       timeout,
    output logic [7:0] cur_addr
);

    // Counter just wide enough to hold TIMEOUT; one bit when the watchdog is off.
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [1:0] SEQ_JUMP = 2'b00;
    localparam logic [1:0] SEQ_DISP = 2'b01;
    localparam logic [1:0] SEQ_COND = 2'b10;
    localparam logic [1:0] SEQ_NEXT = 2'b11;

    logic [7:0]       cur_addr_reg;
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] stall_cnt_next;
    logic [7:0]       seq_addr;
    logic [7:0]       incr_addr;
    logic             wd_trip;

    assign cur_addr  = cur_addr_reg;
    assign incr_addr = cur_addr_reg + 8'd1;

    // The watchdog only exists when a nonzero limit is configured.
    generate
        if (TIMEOUT != 0) begin : g_wd
            assign wd_trip = mem_busy && (stall_cnt_reg == CNT_TRIP);
        end else begin : g_no_wd
            assign wd_trip = 1'b0;
        end
    endgenerate

    // Plain sequencing choice from the current ROM word, ignoring irq and stalls.
    always_comb begin
        seq_addr = incr_addr;
        case (ucode_seq)
            SEQ_JUMP: seq_addr = ucode_naddr;
            SEQ_DISP: seq_addr = {DISP_BASE[7:5], opcode};
            SEQ_COND: seq_addr = cond ? ucode_naddr : incr_addr;
            SEQ_NEXT: seq_addr = incr_addr;
            default:  seq_addr = incr_addr;
        endcase
    end

    // Priority select: reset, watchdog trap, stall hold, interrupt, sequencing.
    always_comb begin
        minx           = cur_addr_reg;
        progress_ucode = 1'b1;
        irq_ack        = 1'b0;
        timeout        = 1'b0;
        stall_cnt_next = stall_cnt_reg;
        if (rst) begin
            minx           = RESET_VEC;
            stall_cnt_next = '0;
        end else if (wd_trip) begin
            minx           = TRAP_VEC;
            timeout        = 1'b1;
            stall_cnt_next = '0;
        end else if (mem_busy) begin
            // Hold the ROM output; the re-presented address is harmless since
            // the ROM ignores it with the enable low.
            progress_ucode = 1'b0;
            minx           = cur_addr_reg;
            if (stall_cnt_reg != CNT_SAT) begin
                stall_cnt_next = stall_cnt_reg + CNT_W'(1);
            end
        end else begin
            stall_cnt_next = '0;
            if ((ucode_seq == SEQ_DISP) && irq) begin
                // Interrupts are only taken between instructions.
                minx    = IRQ_VEC;
                irq_ack = 1'b1;
            end else begin
                minx = seq_addr;
            end
        end
    end

    // Track the address of the word the ROM will present next cycle, plus the stall count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr_reg  <= RESET_VEC;
            stall_cnt_reg <= '0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            if (progress_ucode) begin
                cur_addr_reg <= minx;
            end
        end
    end

endmodule

// File: tb/tb_m_ucode_seq.sv
`timescale 1ns/1ps
// Directed bench for m_ucode_seq: the bench plays the ROM by driving the
// sequencing fields directly; expectations are queued per step and checked
// mid-cycle. A second instance with the watchdog disabled shares the inputs.
module tb_m_ucode_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] ucode_naddr;
    logic [1:0] ucode_seq;
    logic       cond;
    logic [4:0] opcode;
    logic       irq;
    logic       mem_busy;

    logic [7:0] minx, cur_addr;
    logic       progress_ucode, irq_ack, timeout;
    logic [7:0] minx0, cur_addr0;
    logic       progress_ucode0, irq_ack0, timeout0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] minx;
        logic       prog;
        logic       ack;
        logic       tmo;
        logic [7:0] cur;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    m_ucode_seq #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .ucode_naddr(ucode_naddr), .ucode_seq(ucode_seq),
        .cond(cond), .opcode(opcode), .irq(irq), .mem_busy(mem_busy),
        .minx(minx), .progress_ucode(progress_ucode), .irq_ack(irq_ack),
        .timeout(timeout), .cur_addr(cur_addr)
    );

    m_ucode_seq #(.TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .ucode_naddr(ucode_naddr), .ucode_seq(ucode_seq),
        .cond(cond), .opcode(opcode), .irq(irq), .mem_busy(mem_busy),
        .minx(minx0), .progress_ucode(progress_ucode0), .irq_ack(irq_ack0),
        .timeout(timeout0), .cur_addr(cur_addr0)
    );

    task automatic chk(input string tag, input string fld,
                       input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s got %h expected %h", tag, fld, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, queue the expectation, check at negedge.
    task automatic step(input string tag, input logic r, input logic [1:0] s,
                        input logic [7:0] na, input logic c, input logic i,
                        input logic mb, input logic [7:0] e_minx, input logic e_prog,
                        input logic e_ack, input logic e_tmo, input logic [7:0] e_cur);
        exp_t  e;
        string t;
        rst = r; ucode_seq = s; ucode_naddr = na; cond = c; irq = i; mem_busy = mb;
        exp_q.push_back('{e_minx, e_prog, e_ack, e_tmo, e_cur});
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk(t, "minx", minx, e.minx);
        chk(t, "progress_ucode", {7'd0, progress_ucode}, {7'd0, e.prog});
        chk(t, "irq_ack", {7'd0, irq_ack}, {7'd0, e.ack});
        chk(t, "timeout", {7'd0, timeout}, {7'd0, e.tmo});
        chk(t, "cur_addr", cur_addr, e.cur);
        $display("step %-12s minx=%h prog=%b ack=%b tmo=%b cur=%h",
                 t, minx, progress_ucode, irq_ack, timeout, cur_addr);
        @(posedge clk);
        #1;
    endtask

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time bound");
        $fatal(1, "time bound expired");
    end

    initial begin
        int p0;
        int p1;
        logic [7:0] e_cur;
        logic       trap;
        rst = 1'b1; ucode_naddr = 8'h00; ucode_seq = 2'b11; cond = 1'b0;
        opcode = 5'b01100; irq = 1'b0; mem_busy = 1'b0;
        @(posedge clk);
        #1;

        // Reset: RESET_VEC fetched, then sequential run from it.
        step("rst0", 1, 2'b11, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00);
        step("rst1", 1, 2'b11, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00);
        step("rst2", 1, 2'b11, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 8'h00);
        step("seq0", 0, 2'b11, 8'h00, 0, 0, 0, 8'h01, 1, 0, 0, 8'h00);
        step("seq1", 0, 2'b11, 8'h00, 0, 0, 0, 8'h02, 1, 0, 0, 8'h01);
        step("seq2", 0, 2'b11, 8'h00, 0, 0, 0, 8'h03, 1, 0, 0, 8'h02);

        // Wrap of the increment.
        step("jmp_ff", 0, 2'b00, 8'hFF, 0, 0, 0, 8'hFF, 1, 0, 0, 8'h03);
        step("wrap", 0, 2'b11, 8'h00, 0, 0, 0, 8'h00, 1, 0, 0, 8'hFF);

        // Jump and conditional branch.
        step("jmp_5a", 0, 2'b00, 8'h5A, 0, 0, 0, 8'h5A, 1, 0, 0, 8'h00);
        step("jmp_12", 0, 2'b00, 8'h12, 0, 0, 0, 8'h12, 1, 0, 0, 8'h5A);
        step("br_taken", 0, 2'b10, 8'h30, 1, 0, 0, 8'h30, 1, 0, 0, 8'h12);
        step("jmp_12b", 0, 2'b00, 8'h12, 0, 0, 0, 8'h12, 1, 0, 0, 8'h30);
        step("br_not", 0, 2'b10, 8'h30, 0, 0, 0, 8'h13, 1, 0, 0, 8'h12);

        // Dispatch and interrupt.
        step("disp", 0, 2'b01, 8'h00, 0, 0, 0, 8'h2C, 1, 0, 0, 8'h13);
        step("disp_irq", 0, 2'b01, 8'h00, 0, 1, 0, 8'h08, 1, 1, 0, 8'h2C);
        step("irq_seq", 0, 2'b11, 8'h00, 0, 1, 0, 8'h09, 1, 0, 0, 8'h08);
        step("irq_jmp", 0, 2'b00, 8'h40, 0, 1, 0, 8'h40, 1, 0, 0, 8'h09);
        step("jmp_41", 0, 2'b00, 8'h41, 0, 0, 0, 8'h41, 1, 0, 0, 8'h40);

        // Stall with a pending interrupt at a dispatch word.
        for (int k = 0; k < 5; k++) begin
            step("stall", 0, 2'b01, 8'h00, 0, 1, 1, 8'h41, 0, 0, 0, 8'h41);
        end
        step("stall_rel", 0, 2'b11, 8'h00, 0, 1, 0, 8'h42, 1, 0, 0, 8'h41);
        step("disp_after", 0, 2'b01, 8'h00, 0, 1, 0, 8'h08, 1, 1, 0, 8'h42);

        // Watchdog: trap in stall cycle 16, again 16 cycles later.
        for (int k = 1; k <= 32; k++) begin
            trap  = ((k % 16) == 0);
            e_cur = (k <= 16) ? 8'h08 : 8'h04;
            step("wd", 0, 2'b11, 8'h00, 0, 0, 1, trap ? 8'h04 : e_cur,
                 trap, 0, trap, e_cur);
        end

        // Long stall: disabled watchdog never fires, enabled one keeps a 16-cycle period.
        p0 = 0;
        p1 = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (timeout0 === 1'b1) p0++;
            if (timeout === 1'b1) p1++;
            @(posedge clk);
            #1;
        end
        chk("wd_off_1000", "pulses", 8'(p0), 8'd0);
        chk("wd_on_1000", "pulses", 8'(p1), 8'd62);
        $display("long_stall dut0_pulses=%0d dut_pulses=%0d", p0, p1);

        // Reset in the middle of a stall.
        step("rel2", 0, 2'b00, 8'h41, 0, 0, 0, 8'h41, 1, 0, 0, 8'h04);
        for (int k = 0; k < 10; k++) begin
            step("stall10", 0, 2'b11, 8'h00, 0, 0, 1, 8'h41, 0, 0, 0, 8'h41);
        end
        step("rst_mid", 1, 2'b11, 8'h00, 0, 0, 1, 8'h00, 1, 0, 0, 8'h41);
        chk("rst_mid", "stall_cnt", 8'(dut.stall_cnt_reg), 8'h00);
        for (int k = 0; k < 15; k++) begin
            step("post_rst", 0, 2'b11, 8'h00, 0, 0, 1, 8'h00, 0, 0, 0, 8'h00);
        end
        step("wd_post_rst", 0, 2'b11, 8'h00, 0, 0, 1, 8'h04, 1, 0, 1, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
